// File: rtl/counter_pkg.sv
// Shared definitions for the start/stop/pause timer controller and its counter core.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int   DEF_WIDTH = 4;
   localparam logic CNT_UP    = 1'b1;
   localparam logic CNT_DOWN  = 1'b0;

endpackage

// File: rtl/counter_ctrl_cnt_core.sv
// Synchronous loadable up/down counter with hold enable and a combinational terminal compare.
module cnt_core
   import counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic [WIDTH-1:0] term_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_term_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Load takes precedence over stepping; with neither the value holds.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = (up_i == CNT_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign at_term_o = (count_q == term_i);

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/pause sequencing FSM around cnt_core: one-shot or periodic, up or down,
// with a one-cycle done pulse at each terminal-count event.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             periodic,
   input  logic             up_down,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             expired,
   output logic [1:0]       state
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             periodic_q, periodic_d;
   logic             up_q, up_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             expired_q, expired_d;

   logic             cnt_load;
   logic [WIDTH-1:0] cnt_load_val;
   logic             cnt_en;
   logic             cnt_up;
   logic [WIDTH-1:0] term;
   logic             at_term;

   assign term = (up_q == CNT_UP) ? lim_q : '0;

   always_comb begin
      state_d      = state_q;
      lim_d        = lim_q;
      periodic_d   = periodic_q;
      up_d         = up_q;
      done_d       = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;
      cnt_up       = up_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               // Config is taken straight from the inputs on the start edge.
               lim_d        = load_val;
               periodic_d   = periodic;
               up_d         = up_down;
               cnt_load     = 1'b1;
               cnt_load_val = (up_down == CNT_UP) ? '0 : load_val;
               state_d      = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (pause) begin
               state_d = PAUSE;
            end else if (at_term) begin
               done_d = 1'b1;
               if (periodic_q) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = (up_q == CNT_UP) ? '0 : lim_q;
               end else begin
                  state_d = DONE;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         PAUSE: begin
            // Resume edge only changes state; counting restarts on the following edge.
            if (stop) begin
               state_d = IDLE;
            end else if (!pause) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d == RUN) || (state_d == PAUSE);
      expired_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         lim_q      <= '0;
         periodic_q <= 1'b0;
         up_q       <= CNT_DOWN;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         expired_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lim_q      <= lim_d;
         periodic_q <= periodic_d;
         up_q       <= up_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         expired_q  <= expired_d;
      end
   end

   cnt_core #(
      .WIDTH (WIDTH)
   ) u_cnt_core (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .en_i       (cnt_en),
      .up_i       (cnt_up),
      .term_i     (term),
      .count_o    (count),
      .at_term_o  (at_term)
   );

   assign busy    = busy_q;
   assign done    = done_q;
   assign expired = expired_q;
   assign state   = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: reset, one-shot, periodic, pause-at-terminal and edge cases.
module tb_counter_ctrl;

   logic       clk;
   logic       rstn;
   logic       start;
   logic       stop;
   logic       pause;
   logic       periodic;
   logic       up_down;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       expired;
   logic [1:0] state;

   int checks;
   int failures;

   counter_ctrl #(
      .WIDTH (4)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .periodic (periodic),
      .up_down  (up_down),
      .load_val (load_val),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .expired  (expired),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Checks all outputs at once: state, count, busy, done, expired.
   task automatic chk_all(input string tag, input int st, input int cnt,
                          input int bsy, input int dn, input int exd);
      chk({tag, ".state"},   int'(state),   st);
      chk({tag, ".count"},   int'(count),   cnt);
      chk({tag, ".busy"},    int'(busy),    bsy);
      chk({tag, ".done"},    int'(done),    dn);
      chk({tag, ".expired"}, int'(expired), exd);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rstn     = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      pause    = 1'b0;
      periodic = 1'b0;
      up_down  = 1'b0;
      load_val = 4'd0;

      tick();
      tick();
      chk_all("reset", 0, 0, 0, 0, 0);
      rstn = 1'b1;
      tick();
      chk_all("idle_after_reset", 0, 0, 0, 0, 0);

      // Reset mid-run: down lim=5
      start = 1'b1; up_down = 1'b0; periodic = 1'b0; load_val = 4'd5;
      tick();
      start = 1'b0;
      chk_all("rst_run.start", 1, 5, 1, 0, 0);
      tick();
      chk("rst_run.c4", int'(count), 4);
      tick();
      chk("rst_run.c3", int'(count), 3);
      #2 rstn = 1'b0;
      #1;
      chk_all("rst_run.async", 0, 0, 0, 0, 0);
      tick();
      rstn = 1'b1;
      tick();
      tick();
      chk_all("rst_run.idle", 0, 0, 0, 0, 0);

      // One-shot down lim=3
      start = 1'b1; up_down = 1'b0; periodic = 1'b0; load_val = 4'd3;
      tick();
      start = 1'b0;
      chk_all("os_down.3", 1, 3, 1, 0, 0);
      tick();
      chk_all("os_down.2", 1, 2, 1, 0, 0);
      tick();
      chk_all("os_down.1", 1, 1, 1, 0, 0);
      tick();
      chk_all("os_down.0", 1, 0, 1, 0, 0);
      tick();
      chk_all("os_down.done", 3, 0, 0, 1, 1);
      tick();
      chk_all("os_down.hold", 3, 0, 0, 0, 1);

      // start+stop together in DONE: stop wins
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk_all("done_start_stop", 0, 0, 0, 0, 0);

      // Periodic up lim=2, with a start attempt in RUN that must be ignored
      start = 1'b1; up_down = 1'b1; periodic = 1'b1; load_val = 4'd2;
      tick();
      start = 1'b0;
      chk_all("per_up.0a", 1, 0, 1, 0, 0);
      tick();
      chk_all("per_up.1a", 1, 1, 1, 0, 0);
      start = 1'b1; load_val = 4'd7; up_down = 1'b0;
      tick();
      start = 1'b0;
      chk_all("per_up.2a", 1, 2, 1, 0, 0);
      tick();
      chk_all("per_up.0b", 1, 0, 1, 1, 0);
      tick();
      chk_all("per_up.1b", 1, 1, 1, 0, 0);
      tick();
      chk_all("per_up.2b", 1, 2, 1, 0, 0);
      tick();
      chk_all("per_up.0c", 1, 0, 1, 1, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("per_up.stop", 0, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      chk_all("per_up.quiet", 0, 0, 0, 0, 0);

      // Stop in IDLE has no effect
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("idle_stop", 0, 0, 0, 0, 0);

      // Pause coinciding with terminal: down lim=2 one-shot
      start = 1'b1; up_down = 1'b0; periodic = 1'b0; load_val = 4'd2;
      tick();
      start = 1'b0;
      chk_all("pause_t.2", 1, 2, 1, 0, 0);
      tick();
      chk_all("pause_t.1", 1, 1, 1, 0, 0);
      tick();
      chk_all("pause_t.0", 1, 0, 1, 0, 0);
      pause = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_all("pause_t.held", 2, 0, 1, 0, 0);
      end
      pause = 1'b0;
      tick();
      chk_all("pause_t.resume", 1, 0, 1, 0, 0);
      tick();
      chk_all("pause_t.done", 3, 0, 0, 1, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("pause_t.stop", 0, 0, 0, 0, 0);

      // lim=0 periodic: done every cycle
      start = 1'b1; up_down = 1'b0; periodic = 1'b1; load_val = 4'd0;
      tick();
      start = 1'b0;
      chk_all("lim0.start", 1, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("lim0.pulse", 1, 0, 1, 1, 0);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("lim0.stop", 0, 0, 0, 0, 0);

      // Full width: up lim=15 one-shot, no wrap
      start = 1'b1; up_down = 1'b1; periodic = 1'b0; load_val = 4'd15;
      tick();
      start = 1'b0;
      chk_all("w15.0", 1, 0, 1, 0, 0);
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk_all("w15.step", 1, i, 1, 0, 0);
      end
      tick();
      chk_all("w15.done", 3, 15, 0, 1, 1);
      tick();
      chk_all("w15.hold", 3, 15, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
